multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the 16-bit RISC core. Fetches instructions over a
//  ready handshake, decodes them and drives the register file (RA/RB/RW/en), the
//  ALU and data memory. Sits directly upstream of the register file. Sequences
//  FETCH→DECODE→EXEC→[MEM]→[WB] and owns the PC.
// PARAMETERS
//  PC_RESET  16'h0000  PC value loaded on reset
// PORTS
//  clk          in   1   system clock, all state updates on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   instruction fetch request, held until imem_ready
//  imem_ready   in   1   instr valid this cycle (sampled only in FETCH)
//  instr        in   16  instruction word from instruction memory
//  pc           out  16  program counter, also the fetch address
//  RA           out  3   regfile read address A
//  RB           out  3   regfile read address B
//  RW           out  3   regfile write address
//  reg_wr_en    out  1   regfile write enable (drives en)
//  alu_op       out  2   00 add, 01 sub, 10 and, 11 or
//  alu_src_imm  out  1   1 = ALU B operand is imm_ext, 0 = BUSB
//  imm_ext      out  16  sign-extended instr[5:0]
//  alu_zero     in   1   ALU result == 0 (valid in EXEC)
//  mem_rd       out  1   data-memory read strobe, held until mem_ready
//  mem_wr       out  1   data-memory write strobe, held until mem_ready
//  mem_ready    in   1   data-memory access complete (sampled only in MEM)
//  wb_sel       out  1   1 = write back memory data, 0 = ALU result
//  halted       out  1   high while in HALT
// BEHAVIOUR
//  Format: op=instr[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], tgt=[11:0].
//  Opcodes: 0-3 ADD/SUB/AND/OR rd=rs1 op rs2; 4 ADDI rd=rs1+imm; 5 LW rd=M[rs1+imm];
//   6 SW M[rs1+imm]=rd; 7 BEQ if rd==rs1 then pc+=imm; 8 JMP pc={pc[15:12],tgt};
//   F HALT; all others are NOP (DECODE→FETCH).
//  Reset (async): state=FETCH, pc=PC_RESET, IR=0. All strobes (imem_req, reg_wr_en,
//   mem_rd, mem_wr) and RA/RB/RW, alu_op, alu_src_imm, wb_sel, halted are 0.
//   Reset asserted mid-instruction aborts it; no regfile or memory write completes.
//  FETCH: imem_req=1. On imem_ready: IR<=instr, pc<=pc+1 (wraps FFFF→0000), →DECODE.
//  DECODE: RA<=rs1; RB<=rd for SW/BEQ, else rs2. JMP: pc<=target, →FETCH.
//   HALT→HALT. NOP→FETCH. Everything else→EXEC.
//  EXEC: BUSA/BUSB are valid (the regfile reads one cycle after RA/RB).
//   alu_op: 0/1 for SUB and BEQ, 0/0 for ADDI/LW/SW, op[1:0] for R-type.
//   alu_src_imm=1 for ADDI/LW/SW.
//   Next state: R-type/ADDI→WB. LW/SW→MEM.
//   BEQ: if alu_zero, pc<=pc+imm_ext (pc already incremented, mod 2^16); →FETCH.
//  MEM: mem_rd (LW) or mem_wr (SW) held high until mem_ready.
//   On mem_ready: LW→WB, SW→FETCH.
//  WB: reg_wr_en=1 for exactly one cycle, RW=rd, wb_sel=1 for LW. →FETCH.
//   rd=0 is still issued; the regfile discards writes to R0.
//  RA/RB/alu controls hold stable from DECODE until the FSM returns to FETCH.
//   imm_ext is combinational from IR.
//  Handshakes: imem_ready outside FETCH and mem_ready outside MEM are ignored.
//   Strobes are registered and glitch-free. No timeout.
//  Latency with zero-wait memories: R/ADDI 4 cycles; LW 5; SW 4; BEQ 3; JMP/NOP 2.
//  HALT: halted=1 and no strobes are driven; only reset exits.
// TESTING
//  1 Reset: drop rst_n mid-WB → reg_wr_en falls immediately, pc=0000, state=FETCH.
//  2 ADD R3=R1+R2 (instr 16'h0650), imem_ready tied 1 → RA=1 and RB=2 in DECODE;
//    reg_wr_en pulses exactly once with RW=3 on cycle 4; pc=0001.
//  3 LW R2,3(R1) (16'h5443) with mem_ready delayed 3 cycles → mem_rd high 4 cycles,
//    alu_src_imm=1, imm_ext=0003, WB has wb_sel=1 and RW=2.
//  4 BEQ imm=-2 (imm6=6'h3E) at pc=0010, alu_zero=1 → pc=000F.
//    Same instruction with alu_zero=0 → pc=0011, no reg_wr_en.
//  5 JMP tgt=0x123 at pc=5FFF → pc=5123.
//    Fetch at pc=FFFF → pc wraps to 0000.
//  6 SW R4,1(R5) → mem_wr high until mem_ready, RB=4, no reg_wr_en.
//    Then HALT 16'hF000 → halted=1; FSM stays in HALT for 20 cycles until rst_n.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit RISC core: sequences FETCH/DECODE/EXEC/MEM/WB,
// owns the PC and drives regfile addresses, ALU controls and data-memory strobes.
module multicycle_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [2:0]  RA,
  output logic [2:0]  RB,
  output logic [2:0]  RW,
  output logic        reg_wr_en,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic [15:0] imm_ext,
  input  logic        alu_zero,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  output logic        wb_sel,
  output logic        halted,
  output logic [2:0]  state_dbg   // 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
);

  // Handshakes: imem_req / mem_rd / mem_wr are registered requests held high until a
  // clock edge sees the matching ready; a ready arriving while its request is low is ignored.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  ipc_hi;
  logic [3:0]  op;
  logic [2:0]  rd;
  logic [3:0]  f_op;
  logic [1:0]  f_alu_op;
  logic        f_src_imm;
  logic        f_rb_rd;

  assign op        = ir[15:12];
  assign rd        = ir[11:9];
  assign f_op      = instr[15:12];
  assign imm_ext   = {{10{ir[5]}}, ir[5:0]};
  assign state_dbg = state;

  // Read addresses and ALU controls are decoded straight from the fetched word so the
  // regfile sees RA/RB during DECODE and BUSA/BUSB are valid in EXEC.
  always_comb begin
    f_alu_op  = 2'b00;
    f_src_imm = 1'b0;
    f_rb_rd   = 1'b0;
    case (f_op)
      4'h0, 4'h1, 4'h2, 4'h3: f_alu_op = f_op[1:0];
      OP_ADDI, OP_LW:         f_src_imm = 1'b1;
      OP_SW: begin
        f_src_imm = 1'b1;
        f_rb_rd   = 1'b1;
      end
      OP_BEQ: begin
        f_alu_op = 2'b01;
        f_rb_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= PC_RESET;
      ir          <= '0;
      ipc_hi      <= '0;
      imem_req    <= 1'b0;
      RA          <= '0;
      RB          <= '0;
      RW          <= '0;
      reg_wr_en   <= 1'b0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      wb_sel      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            ir          <= instr;
            ipc_hi      <= pc[15:12];
            pc          <= pc + 16'd1;
            imem_req    <= 1'b0;
            RA          <= instr[8:6];
            RB          <= f_rb_rd ? instr[11:9] : instr[5:3];
            alu_op      <= f_alu_op;
            alu_src_imm <= f_src_imm;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_JMP: begin
              // Target page comes from the address the JMP was fetched from.
              pc       <= {ipc_hi, ir[11:0]};
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            4'h0, 4'h1, 4'h2, 4'h3, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state <= S_EXEC;
            default: begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          case (op)
            OP_LW: begin
              mem_rd <= 1'b1;
              state  <= S_MEM;
            end
            OP_SW: begin
              mem_wr <= 1'b1;
              state  <= S_MEM;
            end
            OP_BEQ: begin
              if (alu_zero) pc <= pc + imm_ext;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            default: begin
              reg_wr_en <= 1'b1;
              RW        <= rd;
              wb_sel    <= 1'b0;
              state     <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (op == OP_LW) begin
              reg_wr_en <= 1'b1;
              RW        <= rd;
              wb_sel    <= 1'b1;
              state     <= S_WB;
            end else begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          reg_wr_en <= 1'b0;
          imem_req  <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams checked
// against an instruction-level model of latency, PC, register writes and memory strobes.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [2:0]  RA;
  logic [2:0]  RB;
  logic [2:0]  RW;
  logic        reg_wr_en;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic [15:0] imm_ext;
  logic        alu_zero;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready;
  logic        wb_sel;
  logic        halted;
  logic [2:0]  state_dbg;

  int          total;
  int          bad;
  logic [15:0] model_pc;
  bit          noise;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .pc          (pc),
    .RA          (RA),
    .RB          (RB),
    .RW          (RW),
    .reg_wr_en   (reg_wr_en),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm_ext     (imm_ext),
    .alu_zero    (alu_zero),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ready   (mem_ready),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    mem_ready  = 1'b0;
    alu_zero   = 1'b0;
    instr      = '0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_pc = 16'h0000;
  endtask

  // Presents one instruction, plays the memories and checks everything the instruction
  // should do before the controller asks for the next fetch (or halts).
  task automatic run_instr(input logic [15:0] ins, input int fwait, input int mwait,
                           input logic zero);
    logic [3:0]  op;
    logic [15:0] sext, fetch_pc, exp_pc;
    logic [2:0]  exp_rb, got_rw;
    logic [1:0]  exp_aop;
    logic        exp_src, exp_wbsel, exp_halt, got_wbsel, got_halt, req_drop, hold_bad, done;
    int          exp_lat, exp_wr, exp_rd_cyc, exp_wr_cyc;
    int          edges, wr_cnt, rd_cyc, wr_cyc, k;
    op   = ins[15:12];
    sext = {{10{ins[5]}}, ins[5:0]};
    imem_ready = 1'b0;
    mem_ready  = 1'b0;
    alu_zero   = zero;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL fetch_req got=%b exp=1", imem_req);
      return;
    end
    fetch_pc = model_pc;
    total++;
    if (pc !== fetch_pc) begin
      bad++;
      $display("FAIL fetch_pc got=%h exp=%h", pc, fetch_pc);
    end
    req_drop = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      instr = 16'($urandom);
      @(negedge clk);
      if (imem_req !== 1'b1) req_drop = 1'b1;
    end
    total++;
    if (req_drop) begin
      bad++;
      $display("FAIL imem_req_hold got=dropped exp=held fwait=%0d", fwait);
    end
    instr      = ins;
    imem_ready = 1'b1;

    // Instruction-level model
    exp_pc = fetch_pc + 16'd1;
    exp_wr = 0; exp_wbsel = 1'b0; exp_rd_cyc = 0; exp_wr_cyc = 0; exp_halt = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin exp_lat = 4; exp_wr = 1; end
      4'h5: begin exp_lat = 5 + mwait; exp_wr = 1; exp_wbsel = 1'b1; exp_rd_cyc = mwait + 1; end
      4'h6: begin exp_lat = 4 + mwait; exp_wr_cyc = mwait + 1; end
      4'h7: begin exp_lat = 3; if (zero) exp_pc = exp_pc + sext; end
      4'h8: begin exp_lat = 2; exp_pc = {fetch_pc[15:12], ins[11:0]}; end
      4'hF: begin exp_lat = 2; exp_halt = 1'b1; end
      default: exp_lat = 2;
    endcase
    exp_rb  = (op == 4'h6 || op == 4'h7) ? ins[11:9] : ins[5:3];
    exp_aop = (op == 4'h1 || op == 4'h7) ? 2'b01 : (op <= 4'h3) ? op[1:0] : 2'b00;
    exp_src = (op == 4'h4 || op == 4'h5 || op == 4'h6);

    edges = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; k = 0;
    got_rw = '0; got_wbsel = 1'b0; got_halt = 1'b0; hold_bad = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        total++;
        if (imm_ext !== sext) begin
          bad++;
          $display("FAIL imm_ext ins=%h got=%h exp=%h", ins, imm_ext, sext);
        end
        if (op <= 4'h7) begin
          total++;
          if ({RA, RB} !== {ins[8:6], exp_rb}) begin
            bad++;
            $display("FAIL decode_ra_rb ins=%h got=%h/%h exp=%h/%h", ins, RA, RB, ins[8:6], exp_rb);
          end
          total++;
          if ({alu_op, alu_src_imm} !== {exp_aop, exp_src}) begin
            bad++;
            $display("FAIL alu_ctrl ins=%h got=%b/%b exp=%b/%b", ins, alu_op, alu_src_imm, exp_aop, exp_src);
          end
        end
      end
      if (reg_wr_en === 1'b1) begin
        wr_cnt++;
        got_rw    = RW;
        got_wbsel = wb_sel;
      end
      if (mem_rd === 1'b1) rd_cyc++;
      if (mem_wr === 1'b1) wr_cyc++;
      if (halted === 1'b1) got_halt = 1'b1;
      if (imem_req === 1'b1 || halted === 1'b1 || edges >= 40) begin
        done = 1'b1;
      end else begin
        if (op <= 4'h7 && {RA, RB, alu_op, alu_src_imm} !== {ins[8:6], exp_rb, exp_aop, exp_src})
          hold_bad = 1'b1;
        instr      = 16'($urandom);
        imem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
          k++;
          mem_ready = (k == mwait + 1);
        end else begin
          mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
    imem_ready = 1'b0;
    mem_ready  = 1'b0;

    total++;
    if (edges != exp_lat) begin
      bad++;
      $display("FAIL latency ins=%h got=%0d exp=%0d", ins, edges, exp_lat);
    end
    total++;
    if (got_halt !== exp_halt) begin
      bad++;
      $display("FAIL halted ins=%h got=%b exp=%b", ins, got_halt, exp_halt);
    end
    total++;
    if (hold_bad) begin
      bad++;
      $display("FAIL ctrl_hold ins=%h got=changed exp=stable", ins);
    end
    total++;
    if (wr_cnt != exp_wr) begin
      bad++;
      $display("FAIL wr_pulses ins=%h got=%0d exp=%0d", ins, wr_cnt, exp_wr);
    end
    if (exp_wr == 1) begin
      total++;
      if ({got_rw, got_wbsel} !== {ins[11:9], exp_wbsel}) begin
        bad++;
        $display("FAIL wb_fields ins=%h got=%h/%b exp=%h/%b", ins, got_rw, got_wbsel, ins[11:9], exp_wbsel);
      end
    end
    total++;
    if (rd_cyc != exp_rd_cyc || wr_cyc != exp_wr_cyc) begin
      bad++;
      $display("FAIL mem_strobes ins=%h got=%0d/%0d exp=%0d/%0d", ins, rd_cyc, wr_cyc, exp_rd_cyc, exp_wr_cyc);
    end
    total++;
    if (pc !== exp_pc) begin
      bad++;
      $display("FAIL pc_after ins=%h got=%h exp=%h", ins, pc, exp_pc);
    end
    model_pc = exp_pc;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({imem_req, reg_wr_en, mem_rd, mem_wr, RA, RB, RW, alu_op, alu_src_imm, wb_sel, halted} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {imem_req, reg_wr_en, mem_rd, mem_wr, RA, RB, RW, alu_op, alu_src_imm, wb_sel, halted});
    end
    total++;
    if (pc !== 16'h0000) begin
      bad++;
      $display("FAIL reset_pc got=%h exp=0000", pc);
    end
    rst_n = 1'b1;
    model_pc = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_fetch_req got=%b exp=1", imem_req);
    end
  endtask

  task automatic test_reset_mid_wb();
    int edges;
    do_reset();
    for (int i = 0; i < 5 && imem_req !== 1'b1; i++) @(negedge clk);
    instr      = 16'h0650;
    imem_ready = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      imem_ready = 1'b0;
      edges++;
    end while (reg_wr_en !== 1'b1 && edges < 10);
    total++;
    if (edges != 3 || RW !== 3'd3 || pc !== 16'h0001) begin
      bad++;
      $display("FAIL add_wb_cycle got=%0d/%h/%h exp=3/3/0001", edges, RW, pc);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({reg_wr_en, imem_req, pc} !== 18'd0) begin
      bad++;
      $display("FAIL async_reset_wb got=%b/%b/%h exp=0/0/0000", reg_wr_en, imem_req, pc);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = 16'h0000;
  endtask

  task automatic test_add();
    do_reset();
    run_instr(16'h0650, 0, 0, 1'b0);
    run_instr(16'h1A98, 1, 0, 1'b1);
    run_instr(16'h4E7F, 0, 0, 1'b0);
  endtask

  task automatic test_lw();
    do_reset();
    run_instr(16'h5443, 0, 3, 1'b0);
    run_instr(16'h5443, 2, 0, 1'b0);
  endtask

  task automatic test_beq();
    do_reset();
    run_instr(16'h8010, 0, 0, 1'b0);
    run_instr(16'h707E, 0, 0, 1'b1);
    total++;
    if (pc !== 16'h000F) begin
      bad++;
      $display("FAIL beq_taken got=%h exp=000F", pc);
    end
    run_instr(16'h8010, 0, 0, 1'b0);
    run_instr(16'h707E, 0, 0, 1'b0);
    total++;
    if (pc !== 16'h0011) begin
      bad++;
      $display("FAIL beq_not_taken got=%h exp=0011", pc);
    end
  endtask

  // Walks page by page with JMP to the page end plus a NOP across the boundary.
  task automatic test_page_walk();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      run_instr(16'h8FFF, 0, 0, 1'b0);
      run_instr(16'h9000, 0, 0, 1'b0);
    end
    run_instr(16'h8FFF, 0, 0, 1'b0);
    run_instr(16'h8123, 0, 0, 1'b0);
    total++;
    if (pc !== 16'h5123) begin
      bad++;
      $display("FAIL jmp_page got=%h exp=5123", pc);
    end
    for (int p = 5; p < 16; p++) begin
      run_instr(16'h8FFF, 0, 0, 1'b0);
      run_instr(16'hA000, 0, 0, 1'b0);
    end
    total++;
    if (pc !== 16'h0000) begin
      bad++;
      $display("FAIL pc_wrap got=%h exp=0000", pc);
    end
  endtask

  task automatic test_sw_halt();
    do_reset();
    run_instr(16'h6941, 0, 2, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      instr      = 16'($urandom);
      imem_ready = 1'($urandom_range(0, 1));
      mem_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ({halted, imem_req, reg_wr_en, mem_rd, mem_wr} !== 5'b10000) begin
        bad++;
        $display("FAIL halt_hold cyc=%0d got=%b exp=10000", i, {halted, imem_req, reg_wr_en, mem_rd, mem_wr});
      end
    end
    total++;
    if (pc !== model_pc) begin
      bad++;
      $display("FAIL halt_pc got=%h exp=%h", pc, model_pc);
    end
    do_reset();
    @(negedge clk);
    total++;
    if ({halted, pc} !== 17'd0) begin
      bad++;
      $display("FAIL halt_exit got=%b/%h exp=0/0000", halted, pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    do_reset();
    noise = 1'b1;
    for (int n = 0; n < 80; n++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    noise = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    noise      = 1'b0;
    model_pc   = 16'h0000;
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    instr      = '0;
    alu_zero   = 1'b0;
    mem_ready  = 1'b0;
    test_reset();
    test_reset_mid_wb();
    test_add();
    test_lw();
    test_beq();
    test_page_walk();
    test_sw_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
